// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//   Pays out an owed amount (units of 100) as a sequence of 500/100 coin
//   requests to a coin hopper. It prefers 500 coins while at least 5 units are
//   owed and the 500 tube is not empty. Each request is held until the hopper
//   acknowledges it, and consecutive requests are separated by a fixed idle gap.
//   A request left unacknowledged too long parks the block in FAULT until abort
//   or reset.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   start         one-cycle payout request, honoured only in IDLE
//   amount[3:0]   owed units, sampled with start
//   hopper_ack    hopper confirms one coin dropped (only looked at in REQ)
//   empty500      500 tube empty, sampled on every REQ entry
//   abort         synchronous return to IDLE, overrides everything
//   coin          requested coin type (0 -> 100, 1 -> 500)
//   dispenseCoin  coin request level to the hopper
//   busy          high in every state except IDLE
//   done          one-cycle pulse when a payout completes
//   error         high while in FAULT
//   remaining     units still owed
//   coins_out     coins dispensed in this payout, saturating at 15
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int ACK_TIMEOUT = 15,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       hopper_ack,
  input  logic       empty500,
  input  logic       abort,
  output logic       coin,
  output logic       dispenseCoin,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] remaining,
  output logic [3:0] coins_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int GW = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES  + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          coin_q, coin_d;
  logic          disp_q, disp_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [3:0]    rem_q, rem_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          req_entry_s;

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      gap_q   <= '0;
      coin_q  <= 1'b0;
      disp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      coin_q  <= coin_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; abort wins over every other input.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = (amount != 4'd0) ? S_REQ : S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_REQ: begin
          if (hopper_ack) begin
            state_d = S_GAP;
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = (rem_q != 4'd0) ? S_REQ : S_DONE;
          end else begin
            state_d = S_GAP;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values, derived from the next state.
  always_comb begin
    tmo_d  = tmo_q;
    gap_d  = gap_q;
    coin_d = coin_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    req_entry_s = (state_d == S_REQ) && (state_q != S_REQ);

    if (abort) begin
      // coins_out deliberately keeps its value so the partial payout stays visible
      rem_d  = 4'd0;
      coin_d = 1'b0;
      tmo_d  = '0;
      gap_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_d = amount;
            cnt_d = 4'd0;
          end else begin
            rem_d = rem_q;
          end
        end
        S_REQ: begin
          if (hopper_ack) begin
            rem_d = rem_q - (coin_q ? 4'd5 : 4'd1);
            cnt_d = (cnt_q == 4'd15) ? cnt_q : (cnt_q + 4'd1);
            gap_d = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_GAP: begin
          if (gap_q != GAP_LAST) begin
            gap_d = gap_q + GW'(1);
          end else begin
            gap_d = gap_q;
          end
        end
        default: begin
          tmo_d = tmo_q;
        end
      endcase

      // coin is fixed for the whole request; empty500 is only looked at here
      if (req_entry_s) begin
        tmo_d  = '0;
        coin_d = (rem_d >= 4'd5) && !empty500;
      end else begin
        coin_d = coin_q;
      end
    end

    disp_d = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_FAULT);
  end

  assign coin         = coin_q;
  assign dispenseCoin = disp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign remaining    = rem_q;
  assign coins_out    = cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//   Directed scenarios for change_dispenser. Stimulus pushes the expected
//   sequence of hopper requests / completions / faults into a queue; a monitor
//   pops and compares whenever the DUT raises dispenseCoin, done or error.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int GAP = 2;
  localparam int TMO = 15;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] amount;
  logic       hopper_ack;
  logic       empty500;
  logic       abort;
  logic       coin;
  logic       dispenseCoin;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] remaining;
  logic [3:0] coins_out;

  bit ack_en = 1'b0;
  int errs   = 0;
  int checks = 0;

  // kind: 0 = coin request, 1 = payout done, 2 = fault entry
  typedef struct {
    int         kind;
    logic       coin;
    logic [3:0] rem;
    logic [3:0] cnt;
  } ev_t;

  ev_t exp_q[$];

  change_dispenser #(.ACK_TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .amount       (amount),
    .hopper_ack   (hopper_ack),
    .empty500     (empty500),
    .abort        (abort),
    .coin         (coin),
    .dispenseCoin (dispenseCoin),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .remaining    (remaining),
    .coins_out    (coins_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void push(input int k, input logic c, input logic [3:0] r, input logic [3:0] n);
    ev_t e;
    e.kind = k;
    e.coin = c;
    e.rem  = r;
    e.cnt  = n;
    exp_q.push_back(e);
  endfunction

  task automatic on_event(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL unexpected_event: got kind=%0d coin=%0d rem=%0d cnt=%0d expected no event",
               kind, coin, remaining, coins_out);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == 0 && e.coin !== coin) ||
          e.rem !== remaining || e.cnt !== coins_out) begin
        errs++;
        $display("FAIL event: got kind=%0d coin=%0d rem=%0d cnt=%0d expected kind=%0d coin=%0d rem=%0d cnt=%0d",
                 kind, coin, remaining, coins_out, e.kind, e.coin, e.rem, e.cnt);
      end
    end
  endtask

  // Hopper model: acknowledges a request one cycle after it appears.
  initial begin
    hopper_ack = 1'b0;
    forever begin
      @(negedge clk);
      hopper_ack = ack_en && dispenseCoin;
    end
  end

  // Monitor: compares each request/done/fault against the queue, and the
  // idle gap between consecutive requests.
  initial begin
    logic prev_disp, prev_done, prev_err, in_gap;
    int   gap_run;
    prev_disp = 1'b0;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    in_gap    = 1'b0;
    gap_run   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (dispenseCoin && !prev_disp) on_event(0);
        if (done && !prev_done)         on_event(1);
        if (error && !prev_err)         on_event(2);
        if (!busy) begin
          in_gap = 1'b0;
        end else if (dispenseCoin && !prev_disp) begin
          if (in_gap) chk("gap_length", gap_run, GAP);
          in_gap = 1'b0;
        end else if (!dispenseCoin && prev_disp) begin
          in_gap  = 1'b1;
          gap_run = 1;
        end else if (in_gap && !dispenseCoin) begin
          gap_run++;
        end
      end else begin
        in_gap = 1'b0;
      end
      prev_disp = dispenseCoin;
      prev_done = done;
      prev_err  = error;
    end
  end

  task automatic do_start(input logic [3:0] a);
    @(negedge clk);
    amount = a;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    for (n = 0; n < 300 && !done; n++) @(negedge clk);
    if (!done) chk({nm, "_timeout"}, 0, 1);
    @(negedge clk);
    chk({nm, "_done_width"}, done, 0);
    chk({nm, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    amount   = 4'd0;
    empty500 = 1'b0;
    abort    = 1'b0;
    #1;
    chk("reset_state", int'({coin, dispenseCoin, busy, done, error, remaining, coins_out}), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // amount 7 with 500s available: 500, 100, 100
    ack_en   = 1'b1;
    empty500 = 1'b0;
    push(0, 1'b1, 4'd7, 4'd0);
    push(0, 1'b0, 4'd2, 4'd1);
    push(0, 1'b0, 4'd1, 4'd2);
    push(1, 1'b0, 4'd0, 4'd3);
    do_start(4'd7);
    chk("a7_busy", busy, 1);
    wait_done("a7");
    chk("a7_coins_out", coins_out, 3);
    repeat (2) @(negedge clk);

    // amount 0: straight to done, no coin request
    push(1, 1'b0, 4'd0, 4'd0);
    do_start(4'd0);
    chk("a0_done_latency", done, 1);
    chk("a0_no_dispense", dispenseCoin, 0);
    @(negedge clk);
    chk("a0_done_width", done, 0);
    chk("a0_coins_out", coins_out, 0);
    repeat (2) @(negedge clk);

    // amount 12 with 500 tube empty: twelve 100 coins
    empty500 = 1'b1;
    for (int i = 0; i < 12; i++) push(0, 1'b0, 4'(12 - i), 4'(i));
    push(1, 1'b0, 4'd0, 4'd12);
    do_start(4'd12);
    wait_done("a12");
    chk("a12_coins_out", coins_out, 12);
    repeat (2) @(negedge clk);

    // amount 5 with no acknowledge: timeout into fault, then abort
    empty500 = 1'b0;
    ack_en   = 1'b0;
    push(0, 1'b1, 4'd5, 4'd0);
    push(2, 1'b0, 4'd5, 4'd0);
    do_start(4'd5);
    n = 0;
    while (dispenseCoin && !error && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", n, TMO);
    chk("tmo_error", error, 1);
    chk("tmo_dispense_off", dispenseCoin, 0);
    chk("tmo_remaining", remaining, 5);
    repeat (3) @(negedge clk);
    chk("fault_persists", error, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_error", error, 0);
    chk("abort_busy", busy, 0);
    chk("abort_remaining", remaining, 0);
    repeat (2) @(negedge clk);

    // reset in the middle of a request for amount 10, then a normal payout of 3
    push(0, 1'b1, 4'd10, 4'd0);
    do_start(4'd10);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", int'({coin, dispenseCoin, busy, done, error, remaining, coins_out}), 0);
    @(negedge clk);
    reset  = 1'b1;
    ack_en = 1'b1;
    push(0, 1'b0, 4'd3, 4'd0);
    push(0, 1'b0, 4'd2, 4'd1);
    push(0, 1'b0, 4'd1, 4'd2);
    push(1, 1'b0, 4'd0, 4'd3);
    do_start(4'd3);
    chk("post_reset_start", busy, 1);
    wait_done("a3");
    chk("a3_coins_out", coins_out, 3);
    repeat (2) @(negedge clk);

    // start 9 while busy on 6 is ignored
    push(0, 1'b1, 4'd6, 4'd0);
    push(0, 1'b0, 4'd1, 4'd1);
    push(1, 1'b0, 4'd0, 4'd2);
    do_start(4'd6);
    do_start(4'd9);
    wait_done("a6");
    chk("a6_coins_out", coins_out, 2);
    repeat (2) @(negedge clk);

    // abort during the gap keeps coins_out
    empty500 = 1'b1;
    push(0, 1'b0, 4'd3, 4'd0);
    do_start(4'd3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("gap_abort_busy", busy, 0);
    chk("gap_abort_coins_out", coins_out, 1);
    chk("gap_abort_remaining", remaining, 0);
    repeat (4) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
